// File: rtl/bus_pkg.sv
// Shared definitions for the lab03 bus sequencer: opcodes, FSM states,
// bus mux source codes and instruction field positions.
package bus_pkg;

  // Low two opcode bits; opcode[2]=1 is the reserved (no-op) group.
  typedef enum logic [1:0] {
    MV  = 2'd0,
    MVI = 2'd1,
    ADD = 2'd2,
    SUB = 2'd3
  } opcode_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    T1   = 2'd1,
    T2   = 2'd2,
    T3   = 2'd3
  } state_e;

  localparam logic [3:0] SEL_C  = 4'd0;
  localparam logic [3:0] SEL_R0 = 4'd1;
  localparam logic [3:0] SEL_A  = 4'd9;

  localparam int FLD_W  = 3;
  localparam int OP_MSB = 15;
  localparam int RX_MSB = 12;
  localparam int RY_MSB = 9;
  localparam int IR_LSB = RY_MSB - FLD_W + 1;
  localparam int IR_W   = OP_MSB - IR_LSB + 1;

  function automatic logic [3:0] sel_reg(input logic [2:0] r);
    return SEL_R0 + {1'b0, r};
  endfunction

endpackage

// File: rtl/bus_ctrl_if.sv
// Instruction issue and bus-control signals between the sequencer and the
// datapath. run is a valid strobe; it is taken only while busy is low (ready = !busy).
interface bus_ctrl_if #(
  parameter int W = 16
);
  logic         run;
  logic [W-1:0] instr;
  logic [3:0]   sel;
  logic [7:0]   r_we;
  logic         a_we;
  logic         x_we;
  logic         c_we;
  logic         alu_sub;
  logic         busy;
  logic         done;
  logic [1:0]   dbg_state;

  modport master (
    output run, instr,
    input  sel, r_we, a_we, x_we, c_we, alu_sub, busy, done, dbg_state
  );

  modport slave (
    input  run, instr,
    output sel, r_we, a_we, x_we, c_we, alu_sub, busy, done, dbg_state
  );
endinterface

// File: rtl/bus_ctrl_dec3to8.sv
// 3-to-8 one-hot decoder with enable; produces the R0-R7 load enables.
module dec3to8 (
  input  logic [2:0] idx,
  input  logic       en,
  output logic [7:0] onehot
);
  always_comb begin
    onehot = '0;
    if (en) onehot[idx] = 1'b1;
  end
endmodule

// File: rtl/bus_ctrl.sv
// Multicycle sequencer for the lab03 datapath: drives the bus mux select and
// the register load enables from a registered state and instruction register.
module bus_ctrl
  import bus_pkg::*;
#(
  parameter int W = 16
) (
  input logic       clk,
  input logic       rst,
  bus_ctrl_if.slave bus
);

  localparam logic [1:0] S_IDLE = IDLE;
  localparam logic [1:0] S_T1   = T1;
  localparam logic [1:0] S_T2   = T2;
  localparam logic [1:0] S_T3   = T3;

  logic [1:0]      state, state_n;
  logic [IR_W-1:0] ir;
  logic [W-1:0]    instr_w;
  logic            unused_instr_bits;

  logic [2:0] rx, ry;
  opcode_e    op;
  logic       reserved;

  logic [3:0] sel_c;
  logic       r_en, a_we_c, x_we_c, c_we_c, alu_sub_c, done_c;
  logic [7:0] r_we_c;

  assign instr_w           = bus.instr;
  assign unused_instr_bits = ^instr_w[IR_LSB-1:0];

  assign reserved = ir[OP_MSB-IR_LSB];
  assign op       = opcode_e'(ir[OP_MSB-IR_LSB-1 -: 2]);
  assign rx       = ir[RX_MSB-IR_LSB -: FLD_W];
  assign ry       = ir[RY_MSB-IR_LSB -: FLD_W];

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
      ir    <= '0;
    end else begin
      state <= state_n;
      if (state == S_IDLE && bus.run) ir <= instr_w[OP_MSB:IR_LSB];
    end
  end

  // Outputs depend only on state and IR; run only steers the next state.
  always_comb begin
    state_n   = state;
    sel_c     = SEL_C;
    r_en      = 1'b0;
    a_we_c    = 1'b0;
    x_we_c    = 1'b0;
    c_we_c    = 1'b0;
    alu_sub_c = 1'b0;
    done_c    = 1'b0;
    case (state)
      S_IDLE: begin
        if (bus.run) state_n = S_T1;
      end
      S_T1: begin
        if (reserved) begin
          done_c  = 1'b1;
          state_n = S_IDLE;
        end else begin
          case (op)
            MV: begin
              sel_c   = sel_reg(ry);
              r_en    = 1'b1;
              done_c  = 1'b1;
              state_n = S_IDLE;
            end
            MVI: begin
              a_we_c  = 1'b1;
              state_n = S_T2;
            end
            ADD, SUB: begin
              sel_c   = sel_reg(rx);
              x_we_c  = 1'b1;
              state_n = S_T2;
            end
            default: state_n = S_IDLE;
          endcase
        end
      end
      S_T2: begin
        state_n = S_IDLE;
        if (!reserved) begin
          case (op)
            MVI: begin
              sel_c  = SEL_A;
              r_en   = 1'b1;
              done_c = 1'b1;
            end
            ADD, SUB: begin
              sel_c     = sel_reg(ry);
              c_we_c    = 1'b1;
              alu_sub_c = (op == SUB);
              state_n   = S_T3;
            end
            default: state_n = S_IDLE;
          endcase
        end
      end
      S_T3: begin
        sel_c   = SEL_C;
        r_en    = 1'b1;
        done_c  = 1'b1;
        state_n = S_IDLE;
      end
      default: state_n = S_IDLE;
    endcase
  end

  dec3to8 u_dec (
    .idx    (rx),
    .en     (r_en),
    .onehot (r_we_c)
  );

  assign bus.sel       = sel_c;
  assign bus.r_we      = r_we_c;
  assign bus.a_we      = a_we_c;
  assign bus.x_we      = x_we_c;
  assign bus.c_we      = c_we_c;
  assign bus.alu_sub   = alu_sub_c;
  assign bus.done      = done_c;
  assign bus.busy      = (state != S_IDLE);
  assign bus.dbg_state = state;

  a_rwe_onehot : assert property (@(posedge clk) disable iff (rst) $onehot0(r_we_c));
  a_we_excl    : assert property (@(posedge clk) disable iff (rst)
                                  $onehot0({|r_we_c, a_we_c, x_we_c, c_we_c}));
  a_sel_range  : assert property (@(posedge clk) disable iff (rst) sel_c <= SEL_A);

endmodule

// File: doc/bus_ctrl.md
# bus_ctrl

Multicycle control sequencer for the lab03 16-bit datapath. It accepts one instruction at a time and drives the source-select code of the shared bus multiplexer. It also drives the load enables of every register that the bus feeds: R0–R7, the data-in holding register A, the ALU operand register X and the ALU result register C. It is the write and sequencing side of the bus, the counterpart of the 10-input bus mux.

## Interface
Parameters:
- `W`, 16: instruction/data word width.

Ports:
- `clk`, input, 1: single clock, rising edge.
- `rst`, input, 1: synchronous, active-high reset.
- `run`, input, 1: instruction valid. Sampled only in IDLE.
- `instr`, input, W: instruction word. Captured into internal IR when `run` is accepted.
- `sel`, output, 4: bus mux source code. 0 = C, 1–8 = R0–R7, 9 = A. Codes 10–15 are never driven.
- `r_we`, output, 8: one-hot load enables for R0–R7.
- `a_we`, output, 1: load A from external data input.
- `x_we`, output, 1: load ALU operand register X from bus.
- `c_we`, output, 1: load C from ALU output.
- `alu_sub`, output, 1: ALU computes X − bus when 1, X + bus when 0.
- `busy`, output, 1: high in every state except IDLE.
- `done`, output, 1: one-cycle pulse in the final state of each instruction.

## Operation
- Instruction fields:
  - `instr[15:13]` opcode.
  - `instr[12:10]` rX (destination / first operand).
  - `instr[9:7]` rY.
  - Bits 6:0 are ignored.
- Opcodes:
  - 000 mv: rX ← rY.
  - 001 mvi: rX ← data input, via A.
  - 010 add: rX ← rX + rY.
  - 011 sub: rX ← rX − rY.
  - 1xx: reserved, executed as a no-op.
- States: IDLE, T1, T2, T3.
  - IDLE: `run`=1 loads IR and moves to T1. `run`=0 stays in IDLE.
- All outputs are Moore functions of state and IR. No output depends combinationally on `run` or `instr`.
- Per-state outputs. Anything not listed is 0; `sel` is 0 unless given.
  - mv:
    - T1: `sel`=1+rY, `r_we[rX]`=1, `done`=1, then IDLE.
  - mvi:
    - T1: `a_we`=1, then T2.
    - T2: `sel`=9, `r_we[rX]`=1, `done`=1, then IDLE.
  - add/sub:
    - T1: `sel`=1+rX, `x_we`=1, then T2.
    - T2: `sel`=1+rY, `c_we`=1, `alu_sub`=(opcode==011), then T3.
    - T3: `sel`=0, `r_we[rX]`=1, `done`=1, then IDLE.
  - reserved:
    - T1: `done`=1, no enables, then IDLE.
- At most one bit of `r_we` is set at any time. Of `r_we`, `a_we`, `x_we` and `c_we`, at most one is active per cycle.
- rX==rY is legal. add R3,R3 doubles R3. mv R3,R3 rewrites R3 with its own value.
- `run` or a changed `instr` while `busy` is ignored. IR holds until the next acceptance.

## Timing
- Reset state:
  - state = IDLE, IR = 0.
  - `sel`=0, `r_we`=0, `a_we`=`x_we`=`c_we`=`alu_sub`=0, `busy`=0, `done`=0.
- `rst` has priority over everything. Asserting it mid-instruction returns the block to IDLE on the next edge; no further enables are issued and there is no `done`.
- Latency, counting from the acceptance edge to the edge that ends the `done` cycle:
  - mv and reserved: 1 cycle.
  - mvi: 2 cycles.
  - add/sub: 3 cycles.
- Back-to-back operation: the block is in IDLE the cycle after `done`. `run` held high there accepts the next instruction, so the minimum issue interval is latency + 1 cycles.
- Register writes take effect at the edge that ends the enabling cycle. A value written in cycle n is visible on the bus in cycle n+1.

## Structure
- Package `bus_pkg`:
  - opcode enum: MV, MVI, ADD, SUB.
  - state enum: IDLE, T1, T2, T3.
  - sel constants: SEL_C=4'd0, SEL_R0=4'd1, SEL_A=4'd9.
  - instruction field bit positions.
- The bus mux uses the same sel constants from `bus_pkg`.
- One sub-module, `dec3to8`: a 3-bit index plus an enable in, 8-bit one-hot out. It generates `r_we`.

## Test plan
- Reset then idle:
  - Hold `rst` 2 cycles, then `run`=0 for 5 cycles.
  - Required: all outputs 0, `busy`=0 throughout.
- mv R5←R2 (`instr`=16'h1500):
  - Required: one cycle with `sel`=3, `r_we`=8'h20, `done`=1.
  - Then `busy`=0.
- mvi R7 (`instr`=16'h3C00):
  - Required: T1 `a_we`=1.
  - T2 `sel`=9, `r_we`=8'h80, `done`=1.
- sub R1,R6 (`instr`=16'h6700):
  - Required: T1 `sel`=2, `x_we`=1.
  - T2 `sel`=7, `c_we`=1, `alu_sub`=1.
  - T3 `sel`=0, `r_we`=8'h02, `done`=1.
- Busy and back-to-back:
  - During add R0,R0, toggle `instr` and hold `run`=1.
  - Required: the sequence is unaffected.
  - Next instruction is accepted in the IDLE cycle after `done`, exactly 4 cycles after the first acceptance.
- Reset mid-instruction:
  - Assert `rst` in T2 of an add.
  - Required: next cycle is IDLE with all outputs 0 and no `done` or `r_we` pulse.
  - A reserved opcode (16'hE000) then gives `done` in T1 with all enables 0.
